// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch path: FSM state encoding and instruction width.
package instruction_fetch_unit_pkg;

  localparam int unsigned INSTR_W = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StLoad = 2'd2,
    StDone = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read bus: ready-based read handshake between fetch unit and memory.
interface instruction_fetch_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  import instruction_fetch_unit_pkg::*;

  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_data;
  logic               mem_ready;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_data,
    input  mem_ready
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_data,
    output mem_ready
  );

endinterface

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register: async reset, jump load, wrapping increment.
module program_counter #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_value,
  output logic [ADDR_W-1:0] pc
);

  // A jump target wins over the post-fetch increment; increment wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads one word per request from instruction memory, strobes it
// into the instruction register and advances the program counter.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       WAIT_MAX = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  output logic                     fetch_done,
  output logic                     busy,
  input  logic                     pc_load,
  input  logic [ADDR_W-1:0]        pc_in,
  output logic [ADDR_W-1:0]        pc_out,
  instruction_fetch_unit_if.master mem,
  output logic                     ir_load,
  output logic [INSTR_W-1:0]       ir_value,
  output logic                     err_timeout
);

  // Last counter value before the timeout fires, so WAIT lasts exactly WAIT_MAX cycles.
  localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

  fetch_state_e state;
  logic         flush;
  logic [7:0]   wait_cnt;

  program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load       (pc_load),
    .inc        (state == StLoad),
    .load_value (pc_in),
    .pc         (pc_out)
  );

  // Fetch sequencer with registered outputs; the jump itself is handled by the PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= '0;
      ir_value     <= '0;
      ir_load      <= 1'b0;
      fetch_done   <= 1'b0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      flush        <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          // A simultaneous jump drops the request; the control unit re-requests.
          if (fetch_req && !pc_load) begin
            mem.mem_addr <= pc_out;
            mem.mem_rd   <= 1'b1;
            wait_cnt     <= '0;
            busy         <= 1'b1;
            state        <= StWait;
          end
        end
        StWait: begin
          if (pc_load) begin
            flush <= 1'b1;
          end
          if (mem.mem_ready) begin
            mem.mem_rd <= 1'b0;
            flush      <= 1'b0;
            // A jump seen now or earlier makes this word stale.
            if (flush || pc_load) begin
              busy  <= 1'b0;
              state <= StIdle;
            end else begin
              ir_value <= mem.mem_data;
              ir_load  <= 1'b1;
              state    <= StLoad;
            end
          end else if (wait_cnt == WaitLast) begin
            err_timeout <= 1'b1;
            mem.mem_rd  <= 1'b0;
            flush       <= 1'b0;
            busy        <= 1'b0;
            state       <= StIdle;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        StLoad: begin
          ir_load    <= 1'b0;
          fetch_done <= 1'b1;
          state      <= StDone;
        end
        StDone: begin
          fetch_done <= 1'b0;
          busy       <= 1'b0;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
